instr_realign: RTL and testbench

INSTR_REALIGN -- requirements
Module: instr_realign

---
 rtl/instr_realign_if.sv | 29 ++
 rtl/instr_realign.sv | 111 +++++++++++
 tb/tb_instr_realign.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/instr_realign_if.sv
// Fetch-side bus of the instruction realigner: memory word in, realigned instruction out.
// mem_valid_i qualifies mem_rdata_i/fetch_pc_i; a word is consumed only in a cycle where
// mem_valid_i=1, stall_i=0 and flush_i=0 (stall_i acts as the inverse of ready).
interface instr_realign_if;
    logic [31:0] mem_rdata_i;
    logic [31:0] fetch_pc_i;
    logic        mem_valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        is_compressed_o;
    logic        pc_half_o;
    logic        misalign_o;
    logic        state_dbg_o;

    modport slave (
        input  mem_rdata_i, fetch_pc_i, mem_valid_i, stall_i, flush_i,
        output instr_o, instr_pc_o, instr_valid_o, is_compressed_o, pc_half_o, misalign_o,
        output state_dbg_o
    );

    modport master (
        output mem_rdata_i, fetch_pc_i, mem_valid_i, stall_i, flush_i,
        input  instr_o, instr_pc_o, instr_valid_o, is_compressed_o, pc_half_o, misalign_o,
        input  state_dbg_o
    );
endinterface

// File: rtl/instr_realign.sv
// Realigns 16/32-bit instructions from 32-bit fetch words, buffering the first half of a
// 32-bit instruction that straddles a word boundary until the following word arrives.
module instr_realign (
    input  logic           clk,
    input  logic           reset,
    instr_realign_if.slave bus
);
    typedef enum logic {ALIGNED = 1'b0, HALF_HELD = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        is_compressed_q, is_compressed_d;
    logic        misalign_q, misalign_d;

    logic        accept;
    logic [15:0] sel;
    logic        compressed;
    logic        hold_match;
    logic        pc_half;

    always_comb begin
        accept     = bus.mem_valid_i & ~bus.stall_i & ~bus.flush_i;
        sel        = bus.fetch_pc_i[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        compressed = (sel[1:0] != 2'b11);
        // Wraps modulo 2^32, so a straddle at 0xFFFF_FFFE completes from address 0.
        hold_match = (state_q == HALF_HELD) && (bus.fetch_pc_i == hold_pc_q + 32'd2);

        state_d         = state_q;
        hold_d          = hold_q;
        hold_pc_d       = hold_pc_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        instr_valid_d   = instr_valid_q;
        is_compressed_d = is_compressed_q;
        misalign_d      = misalign_q;
        pc_half         = 1'b0;

        // A stall without flush freezes everything; otherwise the strobes drop by default.
        if (!bus.stall_i || bus.flush_i) begin
            instr_valid_d = 1'b0;
            misalign_d    = 1'b0;
        end
        if (bus.flush_i) begin
            state_d = ALIGNED;
        end

        if (accept) begin
            state_d = ALIGNED;
            if (bus.fetch_pc_i[0]) begin
                misalign_d = 1'b1;
            end else if (hold_match) begin
                instr_d         = {bus.mem_rdata_i[15:0], hold_q};
                instr_pc_d      = hold_pc_q;
                instr_valid_d   = 1'b1;
                is_compressed_d = 1'b0;
                pc_half         = 1'b1;
            end else if (compressed) begin
                instr_d         = {16'h0000, sel};
                instr_pc_d      = bus.fetch_pc_i;
                instr_valid_d   = 1'b1;
                is_compressed_d = 1'b1;
                pc_half         = 1'b1;
            end else if (!bus.fetch_pc_i[1]) begin
                instr_d         = bus.mem_rdata_i;
                instr_pc_d      = bus.fetch_pc_i;
                instr_valid_d   = 1'b1;
                is_compressed_d = 1'b0;
            end else begin
                // Upper half opens a 32-bit instruction; keep it for the next word.
                hold_d    = bus.mem_rdata_i[31:16];
                hold_pc_d = bus.fetch_pc_i;
                state_d   = HALF_HELD;
                pc_half   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ALIGNED;
            hold_q          <= 16'h0000;
            hold_pc_q       <= 32'h0000_0000;
            instr_q         <= 32'h0000_0000;
            instr_pc_q      <= 32'h0000_0000;
            instr_valid_q   <= 1'b0;
            is_compressed_q <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            hold_pc_q       <= hold_pc_d;
            instr_q         <= instr_d;
            instr_pc_q      <= instr_pc_d;
            instr_valid_q   <= instr_valid_d;
            is_compressed_q <= is_compressed_d;
            misalign_q      <= misalign_d;
        end
    end

    assign bus.instr_o         = instr_q;
    assign bus.instr_pc_o      = instr_pc_q;
    assign bus.instr_valid_o   = instr_valid_q;
    assign bus.is_compressed_o = is_compressed_q;
    assign bus.misalign_o      = misalign_q;
    assign bus.pc_half_o       = pc_half & reset;
    assign bus.state_dbg_o     = state_q;
endmodule

// File: tb/tb_instr_realign.sv
// Directed bench for instr_realign: each step drives one cycle of fetch inputs, checks
// pc_half_o before the edge and the registered outputs just after it.
module tb_instr_realign;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    instr_realign_if bus ();

    instr_realign dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle; pc_half_o is combinational so it is checked before the edge.
    task automatic step(input string tag, input logic v, input logic s, input logic f,
                        input logic [31:0] pc, input logic [31:0] data, input logic exp_half);
        bus.mem_valid_i = v;
        bus.stall_i     = s;
        bus.flush_i     = f;
        bus.fetch_pc_i  = pc;
        bus.mem_rdata_i = data;
        #1;
        check({tag, "_pc_half"}, {31'b0, bus.pc_half_o}, {31'b0, exp_half});
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] instr,
                              input logic [31:0] pc, input logic comp, input logic mis,
                              input logic st);
        check({tag, "_valid"}, {31'b0, bus.instr_valid_o}, {31'b0, v});
        check({tag, "_instr"}, bus.instr_o, instr);
        check({tag, "_pc"}, bus.instr_pc_o, pc);
        check({tag, "_comp"}, {31'b0, bus.is_compressed_o}, {31'b0, comp});
        check({tag, "_mis"}, {31'b0, bus.misalign_o}, {31'b0, mis});
        check({tag, "_state"}, {31'b0, bus.state_dbg_o}, {31'b0, st});
    endtask

    task automatic idle(input string tag, input logic exp_half);
        step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, exp_half);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.stall_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.fetch_pc_i  = 32'h4;
        bus.mem_rdata_i = 32'h1234_0505;
        #1;
        check("rst_pc_half", {31'b0, bus.pc_half_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Aligned 32-bit word
        step("t1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h00A0_0093, 1'b0);
        expect_out("t1", 1'b1, 32'h00A0_0093, 32'h0, 1'b0, 1'b0, 1'b0);

        // Two compressed halves of one word, each fetched separately
        step("t2a", 1'b1, 1'b0, 1'b0, 32'h4, 32'h1234_0505, 1'b1);
        expect_out("t2a", 1'b1, 32'h0000_0505, 32'h4, 1'b1, 1'b0, 1'b0);
        step("t2b", 1'b1, 1'b0, 1'b0, 32'h6, 32'h1234_0505, 1'b1);
        expect_out("t2b", 1'b1, 32'h0000_1234, 32'h6, 1'b1, 1'b0, 1'b0);

        // Straddling 32-bit instruction
        step("t3a", 1'b1, 1'b0, 1'b0, 32'h6, 32'h0093_ABCD, 1'b1);
        expect_out("t3a", 1'b0, 32'h0000_1234, 32'h6, 1'b1, 1'b0, 1'b1);
        step("t3b", 1'b1, 1'b0, 1'b0, 32'h8, 32'h1111_00A0, 1'b1);
        expect_out("t3b", 1'b1, 32'h00A0_0093, 32'h6, 1'b0, 1'b0, 1'b0);
        idle("t4", 1'b0);
        expect_out("t4", 1'b0, 32'h00A0_0093, 32'h6, 1'b0, 1'b0, 1'b0);

        // Straddle held through a 3-cycle stall
        step("t5a", 1'b1, 1'b0, 1'b0, 32'h6, 32'h0093_ABCD, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("t5s", 1'b1, 1'b1, 1'b0, 32'h8, 32'h0000_00A0, 1'b0);
            expect_out("t5s", 1'b0, 32'h00A0_0093, 32'h6, 1'b0, 1'b0, 1'b1);
        end
        step("t5b", 1'b1, 1'b0, 1'b0, 32'h8, 32'h0000_00A0, 1'b1);
        expect_out("t5b", 1'b1, 32'h00A0_0093, 32'h6, 1'b0, 1'b0, 1'b0);
        step("t5v", 1'b1, 1'b1, 1'b0, 32'h20, 32'h0000_0001, 1'b0);
        expect_out("t5v", 1'b1, 32'h00A0_0093, 32'h6, 1'b0, 1'b0, 1'b0);

        // Flush drops the held half
        step("t6a", 1'b1, 1'b0, 1'b0, 32'hE, 32'h0093_5555, 1'b1);
        expect_out("t6a", 1'b0, 32'h00A0_0093, 32'h6, 1'b0, 1'b0, 1'b1);
        step("t6f", 1'b1, 1'b1, 1'b1, 32'h10, 32'hFFFF_0013, 1'b0);
        expect_out("t6f", 1'b0, 32'h00A0_0093, 32'h6, 1'b0, 1'b0, 1'b0);
        step("t6b", 1'b1, 1'b0, 1'b0, 32'h10, 32'hFFFF_0013, 1'b0);
        expect_out("t6b", 1'b1, 32'hFFFF_0013, 32'h10, 1'b0, 1'b0, 1'b0);
        step("t6c", 1'b1, 1'b0, 1'b0, 32'h20, 32'h00A0_0093, 1'b0);
        expect_out("t6c", 1'b1, 32'h00A0_0093, 32'h20, 1'b0, 1'b0, 1'b0);

        // Held half followed by a non-contiguous fetch
        step("t7a", 1'b1, 1'b0, 1'b0, 32'h16, 32'h0093_0000, 1'b1);
        expect_out("t7a", 1'b0, 32'h00A0_0093, 32'h20, 1'b0, 1'b0, 1'b1);
        step("t7b", 1'b1, 1'b0, 1'b0, 32'h40, 32'h00B0_0113, 1'b0);
        expect_out("t7b", 1'b1, 32'h00B0_0113, 32'h40, 1'b0, 1'b0, 1'b0);

        // Straddle across the top of the address space
        step("t8a", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0093_0000, 1'b1);
        expect_out("t8a", 1'b0, 32'h00B0_0113, 32'h40, 1'b0, 1'b0, 1'b1);
        step("t8b", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_00A0, 1'b1);
        expect_out("t8b", 1'b1, 32'h00A0_0093, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Odd PC
        step("t9a", 1'b1, 1'b0, 1'b0, 32'h3, 32'h1234_5678, 1'b0);
        expect_out("t9a", 1'b0, 32'h00A0_0093, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        idle("t9b", 1'b0);
        expect_out("t9b", 1'b0, 32'h00A0_0093, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Reset while a half is held
        step("t10a", 1'b1, 1'b0, 1'b0, 32'h6, 32'h0093_0000, 1'b1);
        expect_out("t10a", 1'b0, 32'h00A0_0093, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step("t10r", 1'b1, 1'b0, 1'b0, 32'h8, 32'h0000_00A0, 1'b0);
        expect_out("t10r", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step("t10b", 1'b1, 1'b0, 1'b0, 32'h8, 32'h0000_00A0, 1'b1);
        expect_out("t10b", 1'b1, 32'h0000_00A0, 32'h8, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
